// File: rtl/neo_port_arbiter.sv
// Two-client round-robin arbiter for the NeoPixel driver's load/send port.
// A grant covers a whole transaction: any number of loads followed by one send.
module neo_port_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  ld_req,
    input  logic [5:0]  ld_pix,
    input  logic [3:0]  ld_col,
    input  logic [15:0] ld_lvl,
    input  logic [1:0]  snd_req,
    output logic [1:0]  grant,
    output logic [1:0]  ld_ack,
    output logic [1:0]  snd_ack,
    input  logic        ready_to_load,
    input  logic        ready_to_send,
    output logic        load_color,
    output logic        send_it,
    output logic [2:0]  pixel_index,
    output logic [1:0]  color_index,
    output logic [7:0]  color_level
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, OWNED, BUSY} state_t;

    state_t        state;
    logic          owner;
    logic          last_owner;
    logic [CW-1:0] idle_cnt;

    logic       next_owner;
    logic       own_req;
    logic       own_ld;
    logic       own_snd;
    logic [1:0] owner_mask;

    // The client after last_owner wins if it requests, otherwise the other one.
    assign next_owner = last_owner ? ~req[0] : req[1];
    assign own_req    = req[owner];
    assign own_ld     = ld_req[owner];
    assign own_snd    = snd_req[owner];
    assign owner_mask = owner ? 2'b10 : 2'b01;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            idle_cnt    <= '0;
            grant       <= 2'b00;
            ld_ack      <= 2'b00;
            snd_ack     <= 2'b00;
            load_color  <= 1'b0;
            send_it     <= 1'b0;
            pixel_index <= 3'd0;
            color_index <= 2'd0;
            color_level <= 8'd0;
        end else begin
            load_color <= 1'b0;
            send_it    <= 1'b0;
            ld_ack     <= 2'b00;
            snd_ack    <= 2'b00;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (req != 2'b00) begin
                        owner <= next_owner;
                        grant <= next_owner ? 2'b10 : 2'b01;
                        state <= OWNED;
                    end
                end
                OWNED: begin
                    // A load blocks the send in the same cycle; the load_color
                    // term keeps either strobe from following a load back to back.
                    if (!own_req) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_owner <= owner;
                    end else if (own_ld && ready_to_load && !load_color) begin
                        load_color  <= 1'b1;
                        ld_ack      <= owner_mask;
                        pixel_index <= owner ? ld_pix[5:3] : ld_pix[2:0];
                        color_index <= owner ? ld_col[3:2] : ld_col[1:0];
                        color_level <= owner ? ld_lvl[15:8] : ld_lvl[7:0];
                        idle_cnt    <= '0;
                    end else if (own_snd && !own_ld && ready_to_send && !load_color) begin
                        send_it  <= 1'b1;
                        snd_ack  <= owner_mask;
                        idle_cnt <= '0;
                        state    <= BUSY;
                    end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_owner <= owner;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                BUSY: begin
                    if (ready_to_load) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_owner <= owner;
                        idle_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neo_port_arbiter.sv
// Directed bench for neo_port_arbiter: a cycle table for one full transaction
// and round-robin hand-off, then hand-written multi-cycle corner sequences.
module tb_neo_port_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  ld_req;
    logic [5:0]  ld_pix;
    logic [3:0]  ld_col;
    logic [15:0] ld_lvl;
    logic [1:0]  snd_req;
    logic [1:0]  grant;
    logic [1:0]  ld_ack;
    logic [1:0]  snd_ack;
    logic        ready_to_load;
    logic        ready_to_send;
    logic        load_color;
    logic        send_it;
    logic [2:0]  pixel_index;
    logic [1:0]  color_index;
    logic [7:0]  color_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  ld_req;
        logic [1:0]  snd_req;
        logic        rtl;
        logic        rts;
        logic [5:0]  pix;
        logic [3:0]  col;
        logic [15:0] lvl;
        logic [20:0] expect_out;
    } vec_t;

    vec_t tbl[18];

    neo_port_arbiter #(.TIMEOUT(8)) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .ld_req(ld_req),
        .ld_pix(ld_pix),
        .ld_col(ld_col),
        .ld_lvl(ld_lvl),
        .snd_req(snd_req),
        .grant(grant),
        .ld_ack(ld_ack),
        .snd_ack(snd_ack),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send),
        .load_color(load_color),
        .send_it(send_it),
        .pixel_index(pixel_index),
        .color_index(color_index),
        .color_level(color_level)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [20:0] pack_out(logic [1:0] g, logic [1:0] la, logic [1:0] sa,
                                             logic lc, logic si, logic [2:0] p,
                                             logic [1:0] c, logic [7:0] l);
        return {g, la, sa, lc, si, p, c, l};
    endfunction

    function automatic vec_t mk(logic [1:0] r, logic [1:0] lr, logic [1:0] sr, logic rtl,
                                logic rts, logic [5:0] pix, logic [3:0] col,
                                logic [15:0] lvl, logic [20:0] exp_out);
        vec_t v;
        v.req = r; v.ld_req = lr; v.snd_req = sr; v.rtl = rtl; v.rts = rts;
        v.pix = pix; v.col = col; v.lvl = lvl; v.expect_out = exp_out;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        req = v.req; ld_req = v.ld_req; snd_req = v.snd_req;
        ready_to_load = v.rtl; ready_to_send = v.rts;
        ld_pix = v.pix; ld_col = v.col; ld_lvl = v.lvl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        req = 2'b00; ld_req = 2'b00; snd_req = 2'b00;
        ld_pix = 6'd0; ld_col = 4'd0; ld_lvl = 16'd0;
        ready_to_load = 1'b1; ready_to_send = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [20:0] outs();
        return {grant, ld_ack, snd_ack, load_color, send_it, pixel_index, color_index, color_level};
    endfunction

    initial begin
        int drop_at, lc_at, si_at, bad;
        logic [1:0] first_g;
        logic sent, prev_strobe;

        reset = 1'b1;
        req = 2'b00; ld_req = 2'b00; snd_req = 2'b00;
        ld_pix = 6'd0; ld_col = 4'd0; ld_lvl = 16'd0;
        ready_to_load = 1'b1; ready_to_send = 1'b1;
        #12;
        checkOutput("reset_state", 32'(outs()), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // T1 burst and send by client 0, BUSY release, then a client 1 load
        tbl[0]  = mk(2'b01, 2'b00, 2'b00, 1, 1, 6'd0, 4'd0, 16'h0000, pack_out(2'b01, 2'b00, 2'b00, 0, 0, 3'd0, 2'd0, 8'h00));
        tbl[1]  = mk(2'b01, 2'b01, 2'b00, 1, 1, 6'd0, 4'd0, 16'h00FF, pack_out(2'b01, 2'b01, 2'b00, 1, 0, 3'd0, 2'd0, 8'hFF));
        tbl[2]  = mk(2'b01, 2'b01, 2'b00, 1, 1, 6'd1, 4'd1, 16'h0080, pack_out(2'b01, 2'b00, 2'b00, 0, 0, 3'd0, 2'd0, 8'hFF));
        tbl[3]  = mk(2'b01, 2'b01, 2'b00, 1, 1, 6'd1, 4'd1, 16'h0080, pack_out(2'b01, 2'b01, 2'b00, 1, 0, 3'd1, 2'd1, 8'h80));
        tbl[4]  = mk(2'b01, 2'b01, 2'b00, 1, 1, 6'd7, 4'd2, 16'h0001, pack_out(2'b01, 2'b00, 2'b00, 0, 0, 3'd1, 2'd1, 8'h80));
        tbl[5]  = mk(2'b01, 2'b01, 2'b00, 1, 1, 6'd7, 4'd2, 16'h0001, pack_out(2'b01, 2'b01, 2'b00, 1, 0, 3'd7, 2'd2, 8'h01));
        tbl[6]  = mk(2'b01, 2'b00, 2'b01, 1, 1, 6'd7, 4'd2, 16'h0001, pack_out(2'b01, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[7]  = mk(2'b01, 2'b00, 2'b01, 1, 1, 6'd7, 4'd2, 16'h0001, pack_out(2'b01, 2'b00, 2'b01, 0, 1, 3'd7, 2'd2, 8'h01));
        tbl[8]  = mk(2'b01, 2'b00, 2'b00, 0, 1, 6'd0, 4'd0, 16'h0000, pack_out(2'b01, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[9]  = mk(2'b01, 2'b01, 2'b01, 0, 1, 6'd3, 4'd3, 16'h0033, pack_out(2'b01, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[10] = mk(2'b01, 2'b00, 2'b00, 1, 1, 6'd0, 4'd0, 16'h0000, pack_out(2'b00, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[11] = mk(2'b01, 2'b00, 2'b00, 1, 1, 6'd0, 4'd0, 16'h0000, pack_out(2'b01, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[12] = mk(2'b00, 2'b00, 2'b00, 1, 1, 6'd0, 4'd0, 16'h0000, pack_out(2'b00, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[13] = mk(2'b00, 2'b00, 2'b00, 1, 1, 6'd0, 4'd0, 16'h0000, pack_out(2'b00, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[14] = mk(2'b10, 2'b01, 2'b00, 1, 1, 6'd4, 4'd1, 16'h0044, pack_out(2'b10, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[15] = mk(2'b10, 2'b01, 2'b01, 1, 1, 6'd4, 4'd1, 16'h0044, pack_out(2'b10, 2'b00, 2'b00, 0, 0, 3'd7, 2'd2, 8'h01));
        tbl[16] = mk(2'b10, 2'b10, 2'b00, 1, 1, 6'b101011, 4'b1101, 16'hA511, pack_out(2'b10, 2'b10, 2'b00, 1, 0, 3'd5, 2'd3, 8'hA5));
        tbl[17] = mk(2'b00, 2'b00, 2'b00, 1, 1, 6'd0, 4'd0, 16'h0000, pack_out(2'b00, 2'b00, 2'b00, 0, 0, 3'd5, 2'd3, 8'hA5));

        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i]);
            tick();
            checkOutput($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].expect_out));
            @(negedge clock);
        end

        // T2 simultaneous requests after reset, hand-off after c0's send
        doReset();
        req = 2'b11;
        tick();
        checkOutput("t2_first_grant", 32'(grant), 32'h1);
        @(negedge clock);
        snd_req = 2'b01;
        tick();
        checkOutput("t2_send", 32'({send_it, snd_ack}), 32'({1'b1, 2'b01}));
        @(negedge clock);
        snd_req = 2'b00;
        ready_to_load = 1'b0;
        tick();
        checkOutput("t2_busy_hold", 32'(grant), 32'h1);
        @(negedge clock);
        ready_to_load = 1'b1;
        tick();
        checkOutput("t2_release", 32'(grant), 32'h0);
        tick();
        checkOutput("t2_rr_grant", 32'(grant), 32'h2);

        // T3 load held off by ready_to_load
        doReset();
        ready_to_load = 1'b0;
        req = 2'b01;
        tick();
        @(negedge clock);
        ld_req = 2'b01; ld_pix = 6'd2; ld_col = 4'd3; ld_lvl = 16'h0042;
        bad = 0;
        repeat (5) begin
            tick();
            if (load_color || ld_ack != 2'b00) bad++;
        end
        checkOutput("t3_no_load", 32'(bad), 32'd0);
        @(negedge clock);
        ready_to_load = 1'b1;
        tick();
        checkOutput("t3_load", 32'({load_color, ld_ack, pixel_index, color_level}),
                    32'({1'b1, 2'b01, 3'd2, 8'h42}));

        // T4 timeout with TIMEOUT=8: grant seen at edge 1, gone at edge 9
        doReset();
        req = 2'b01;
        drop_at = 0; sent = 1'b0; first_g = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) first_g = grant;
            if (send_it) sent = 1'b1;
            if (grant == 2'b00 && drop_at == 0) drop_at = k;
        end
        checkOutput("t4_grant", 32'(first_g), 32'h1);
        checkOutput("t4_drop_edge", 32'(drop_at), 32'd9);
        checkOutput("t4_no_send", 32'(sent), 32'd0);

        // T5 async reset while load_color is high
        doReset();
        req = 2'b01; ld_req = 2'b01; ld_pix = 6'd5; ld_col = 4'd2; ld_lvl = 16'h0033;
        tick();
        tick();
        checkOutput("t5_pre_load", 32'({load_color, grant}), 32'({1'b1, 2'b01}));
        reset = 1'b1;
        #1;
        checkOutput("t5_async_clear", 32'({grant, ld_ack, snd_ack, load_color, send_it}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        req = 2'b11; ld_req = 2'b00;
        tick();
        checkOutput("t5_c0_wins", 32'(grant), 32'h1);

        // T6 load and send requested together
        doReset();
        req = 2'b01;
        tick();
        @(negedge clock);
        ld_req = 2'b01; snd_req = 2'b01; ld_pix = 6'd6; ld_col = 4'd1; ld_lvl = 16'h0077;
        lc_at = 0; si_at = 0; bad = 0; prev_strobe = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (load_color && lc_at == 0) lc_at = k;
            if (send_it && si_at == 0) si_at = k;
            if (load_color && send_it) bad++;
            if (prev_strobe && (load_color || send_it)) bad++;
            prev_strobe = load_color | send_it;
            if (ld_ack[0]) ld_req = 2'b00;
            if (snd_ack[0]) snd_req = 2'b00;
        end
        checkOutput("t6_load_edge", 32'(lc_at), 32'd1);
        checkOutput("t6_send_edge", 32'(si_at), 32'd3);
        checkOutput("t6_strobe_spacing", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
